// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 timing generator streaming an 8-bit grayscale framebuffer image.
// Counter state -> registered address -> RAM data -> registered outputs; fixed 3-cycle latency.
module vga_frame_reader #(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int BASE_ADDR = 0,
   parameter int X0 = 0,
   parameter int Y0 = 0,
   parameter logic [7:0] BORDER = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   output logic [16:0] vga_addr,
   input  logic [7:0]  ram_vga,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        frame_start
);
   localparam logic [9:0] XS = 10'(X0);
   localparam logic [9:0] XW = 10'(IMG_W);
   localparam logic [9:0] YS = 10'(Y0);
   localparam logic [9:0] YH = 10'(IMG_H);
   localparam logic [16:0] BASE = 17'(BASE_ADDR);

   if (BASE_ADDR + IMG_W * IMG_H > 131072 || X0 + IMG_W > 640 || Y0 + IMG_H > 480) begin : g_chk
      $error("vga_frame_reader: image does not fit framebuffer or screen");
   end

   logic [9:0]  r_h, r_v;
   logic [16:0] r_cnt, r_addr;
   logic [4:0]  r_p1, r_p2;
   logic [7:0]  r_pix;
   logic        r_hs, r_vs, r_blank_n, r_fs;
   logic [9:0]  w_hx, w_vy;
   logic        w_img, w_orig, w_hlast;
   logic [16:0] w_cur;
   logic [4:0]  w_s0;

   // Offsets wrap to large values left of/above the image, so one unsigned compare bounds each axis
   assign w_hx = r_h - XS;
   assign w_vy = r_v - YS;
   assign w_img = (w_hx < XW) && (w_vy < YH);
   assign w_orig = (r_h == 10'd0) && (r_v == 10'd0);
   assign w_hlast = r_h == 10'd799;
   assign w_cur = w_orig ? BASE : r_cnt;
   // Stage flags {frame_start, vsync pulse, hsync pulse, image, active}; all-zero is the idle state
   assign w_s0 = {w_orig, (r_v >= 10'd490) && (r_v <= 10'd491), (r_h >= 10'd656) && (r_h <= 10'd751),
                  w_img, (r_h < 10'd640) && (r_v < 10'd480)};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h <= '0;
         r_v <= '0;
         r_cnt <= BASE;
         r_addr <= BASE;
         r_p1 <= '0;
         r_p2 <= '0;
         r_pix <= '0;
         r_hs <= 1'b1;
         r_vs <= 1'b1;
         r_blank_n <= 1'b0;
         r_fs <= 1'b0;
      end else begin
         r_h <= w_hlast ? 10'd0 : r_h + 10'd1;
         if (w_hlast) r_v <= (r_v == 10'd524) ? 10'd0 : r_v + 10'd1;
         r_cnt <= w_img ? w_cur + 17'd1 : w_cur;
         if (w_img) r_addr <= w_cur;
         r_p1 <= w_s0;
         r_p2 <= r_p1;
         r_pix <= !r_p2[0] ? 8'h00 : r_p2[1] ? ram_vga : BORDER;
         r_blank_n <= r_p2[0];
         r_hs <= ~r_p2[2];
         r_vs <= ~r_p2[3];
         r_fs <= r_p2[4];
      end
   end

   assign vga_addr = r_addr;
   assign vga_hsync = r_hs;
   assign vga_vsync = r_vs;
   assign vga_blank_n = r_blank_n;
   assign vga_sync_n = 1'b0;
   assign vga_r = r_pix;
   assign vga_g = r_pix;
   assign vga_b = r_pix;
   assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: random framebuffer contents and reset points, scoreboard against a
// pixel-coordinate reference model.
module tb_vga_frame_reader;
   localparam int W = 200, H = 12, BASE = 1000, XO = 100, YO = 4;
   localparam logic [7:0] BRD = 8'h5A;

   logic clk = 1'b0, rst = 1'b1;
   logic [16:0] vga_addr;
   logic [7:0] ram_vga, vga_r, vga_g, vga_b;
   logic vga_hsync, vga_vsync, vga_blank_n, vga_sync_n, frame_start;
   logic [7:0] mem [0:131071];

   typedef struct packed {int due; logic hs; logic vs; logic bl; logic fs; logic [7:0] pix;} exp_t;
   typedef struct packed {int due; logic [16:0] addr;} aexp_t;
   exp_t q[$];
   aexp_t qa[$];
   exp_t e;
   aexp_t a;
   int k = -1, checks = 0, errors = 0, exp_addr = BASE;

   vga_frame_reader #(.IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE), .X0(XO), .Y0(YO), .BORDER(BRD)) dut (
      .clk(clk), .rst(rst), .vga_addr(vga_addr), .ram_vga(ram_vga),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start)
   );

   always #20 clk = ~clk;

   // Synchronous read RAM: data valid one clock after the address
   always @(posedge clk) ram_vga <= mem[vga_addr];

   function automatic bit in_img(int j);
      int h = j % 800;
      int v = (j / 800) % 525;
      return h >= XO && h < XO + W && v >= YO && v < YO + H;
   endfunction

   function automatic int addr_of(int j);
      int h = j % 800;
      int v = (j / 800) % 525;
      return BASE + (v - YO) * W + (h - XO);
   endfunction

   // Expected outputs for the counter state j cycles after reset; they surface 3 cycles later
   function automatic exp_t model(int j);
      exp_t r;
      int h = j % 800;
      int v = (j / 800) % 525;
      bit act = h < 640 && v < 480;
      r.due = j + 3;
      r.hs = !(h >= 656 && h <= 751);
      r.vs = !(v >= 490 && v <= 491);
      r.bl = act;
      r.fs = (j % 420000) == 0;
      r.pix = !act ? 8'h00 : in_img(j) ? mem[addr_of(j)] : BRD;
      return r;
   endfunction

   task automatic check(string n, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", n, act, exp, k);
      end
   endtask

   // Producer: one issued counter state per clock
   initial forever begin
      @(posedge clk);
      #1;
      if (rst) begin
         k = 0;
         q.delete();
         qa.delete();
         exp_addr = BASE;
         for (int i = 0; i < 3; i++) q.push_back('{due: i, hs: 1'b1, vs: 1'b1, bl: 1'b0, fs: 1'b0, pix: 8'h00});
         qa.push_back('{due: 0, addr: 17'(BASE)});
      end else begin
         k++;
      end
      q.push_back(model(k));
      if (in_img(k)) exp_addr = addr_of(k);
      qa.push_back('{due: k + 1, addr: 17'(exp_addr)});
   end

   // Monitor: pops the expectation due this cycle and compares on the falling edge
   initial forever begin
      @(negedge clk);
      if (k >= 0) begin
         checks++;
         if (q.size() == 0 || qa.size() == 0 || q[0].due != k || qa[0].due != k) begin
            errors++;
            $display("FAIL sched: no expectation queued for cycle %0d", k);
         end else begin
            e = q.pop_front();
            a = qa.pop_front();
            check("vga_addr", vga_addr, a.addr);
            check("vga_r", vga_r, e.pix);
            check("vga_g", vga_g, e.pix);
            check("vga_b", vga_b, e.pix);
            check("vga_hsync", vga_hsync, e.hs);
            check("vga_vsync", vga_vsync, e.vs);
            check("vga_blank_n", vga_blank_n, e.bl);
            check("frame_start", frame_start, e.fs);
            check("vga_sync_n", vga_sync_n, 0);
         end
      end
   end

   initial begin
      for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
      mem[BASE + W * H - 1] = 8'hFF;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (17 * 800) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat ((YO + $urandom_range(0, H - 1)) * 800 + $urandom_range(0, 799)) @(negedge clk);
      rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst = 1'b0;
      repeat (17 * 800) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
